catc_bus_master: RTL and testbench

- Initiator for the CATC 20-bit register/memory bus. It turns queued host commands into the exact addr/data_in cycle sequences the CATC slave decodes, and captures the slave's registered data_out for read commands.
- Command types: EXEC (load opcode, operand A, operand B), STORE (write word via the store slot), READ (fetch memory word).
- Sits between the air-data sequencer and the CATC core. It is the only driver of the CATC address and write-data buses.

---
 rtl/catc_pkg.sv | 34 +++
 rtl/catc_bus_master.sv | 144 ++++++++++++++
 tb/tb_catc_bus_master.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/catc_pkg.sv
// CATC bus master shared types.
// Slot map, command kinds, ALU opcodes and FSM states.
package catc_pkg;

  localparam int CATC_SLOT_OP = 0;
  localparam int CATC_SLOT_A  = 1;
  localparam int CATC_SLOT_B  = 2;
  localparam int CATC_SLOT_ST = 3;

  typedef enum logic [1:0] {
    KIND_EXEC  = 2'b00,
    KIND_STORE = 2'b01,
    KIND_READ  = 2'b10,
    KIND_RSVD  = 2'b11
  } cmd_kind_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_OP,
    S_W_A,
    S_W_B,
    S_W_ST,
    S_GAP,
    S_R_ADDR,
    S_R_CAP,
    S_RSP
  } state_e;

endpackage

// File: rtl/catc_bus_master.sv
// CATC bus initiator: turns host commands into slot write
// sequences and registered reads with a held response.
module catc_bus_master
  import catc_pkg::*;
#(
  parameter int              AW        = 20,
  parameter int              DW        = 20,
  parameter logic [AW-1:0]   IDLE_ADDR = 20'h00010,
  parameter int              WR_GAP    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_kind,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [AW-1:0] cmd_addr,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy
);

  localparam logic [3:0] GAP_LD = 4'(WR_GAP - 1);

  state_e        state, state_nx;
  state_e        ret, ret_nx;
  state_e        wr_tgt;
  logic          wr_done;
  logic [3:0]    gap, gap_nx;
  logic [DW-1:0] a_q, b_q;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] wdata_nx;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    ret_nx   = ret;
    gap_nx   = gap;
    wr_done  = 1'b0;
    wr_tgt   = S_IDLE;
    addr_nx  = IDLE_ADDR;
    wdata_nx = '0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_kind_e'(cmd_kind))
            KIND_EXEC:  state_nx = S_W_OP;
            KIND_STORE: state_nx = S_W_ST;
            KIND_READ:  state_nx = S_R_ADDR;
            KIND_RSVD:  state_nx = S_IDLE;
          endcase
        end
      end
      S_W_OP: begin
        wr_done = 1'b1;
        wr_tgt  = S_W_A;
      end
      S_W_A: begin
        wr_done = 1'b1;
        wr_tgt  = S_W_B;
      end
      S_W_B, S_W_ST: begin
        wr_done = 1'b1;
        wr_tgt  = S_IDLE;
      end
      S_GAP: begin
        if (gap == '0) state_nx = ret;
        else           gap_nx   = gap - 4'd1;
      end
      S_R_ADDR: state_nx = S_R_CAP;
      S_R_CAP:  state_nx = S_RSP;
      S_RSP:    if (rsp_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase

    // every write may be followed by a fixed idle gap
    if (wr_done) begin
      if (WR_GAP > 0) begin
        state_nx = S_GAP;
        ret_nx   = wr_tgt;
        gap_nx   = GAP_LD;
      end else begin
        state_nx = wr_tgt;
      end
    end

    // outputs are registered from the state being entered
    case (state_nx)
      S_W_OP: begin
        addr_nx  = AW'(CATC_SLOT_OP);
        wdata_nx = DW'(cmd_op);
      end
      S_W_A: begin
        addr_nx  = AW'(CATC_SLOT_A);
        wdata_nx = a_q;
      end
      S_W_B: begin
        addr_nx  = AW'(CATC_SLOT_B);
        wdata_nx = b_q;
      end
      S_W_ST: begin
        addr_nx  = AW'(CATC_SLOT_ST);
        wdata_nx = cmd_a;
      end
      S_R_ADDR: addr_nx = cmd_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ret       <= S_IDLE;
      gap       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      bus_addr  <= IDLE_ADDR;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nx;
      ret       <= ret_nx;
      gap       <= gap_nx;
      bus_addr  <= addr_nx;
      bus_wdata <= wdata_nx;
      rsp_valid <= (state_nx == S_RSP);
      if (cmd_valid && cmd_ready) begin
        a_q <= cmd_a;
        b_q <= cmd_b;
      end
      if (state == S_R_CAP) rsp_data <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_catc_bus_master.sv
// Bench for catc_bus_master: directed table, gap variant,
// mid-sequence reset and random commands against a model.
module tb_catc_bus_master;
  import catc_pkg::*;

  localparam int AW = 20;
  localparam int DW = 20;
  localparam logic [AW-1:0] IDLE = 20'h00010;
  localparam int GAP2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_kind = 2'b00;
  logic [2:0]    cmd_op = 3'd0;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          busy;

  logic          g_cmd_valid = 1'b0;
  logic          g_cmd_ready;
  logic [1:0]    g_cmd_kind = 2'b00;
  logic [2:0]    g_cmd_op = 3'd0;
  logic [DW-1:0] g_cmd_a = '0;
  logic [DW-1:0] g_cmd_b = '0;
  logic [AW-1:0] g_cmd_addr = '0;
  logic [AW-1:0] g_bus_addr;
  logic [DW-1:0] g_bus_wdata;
  logic [DW-1:0] g_bus_rdata;
  logic          g_rsp_valid;
  logic          g_rsp_ready = 1'b1;
  logic [DW-1:0] g_rsp_data;
  logic          g_busy;

  assign g_bus_rdata = '0;

  catc_bus_master #(
    .AW(AW), .DW(DW), .IDLE_ADDR(IDLE), .WR_GAP(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_addr(cmd_addr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy)
  );

  catc_bus_master #(
    .AW(AW), .DW(DW), .IDLE_ADDR(IDLE), .WR_GAP(GAP2)
  ) dut_gap (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(g_cmd_valid), .cmd_ready(g_cmd_ready),
    .cmd_kind(g_cmd_kind), .cmd_op(g_cmd_op),
    .cmd_a(g_cmd_a), .cmd_b(g_cmd_b), .cmd_addr(g_cmd_addr),
    .bus_addr(g_bus_addr), .bus_wdata(g_bus_wdata),
    .bus_rdata(g_bus_rdata),
    .rsp_valid(g_rsp_valid), .rsp_ready(g_rsp_ready),
    .rsp_data(g_rsp_data), .busy(g_busy)
  );

  // CATC slave stand-in: slots 0..3 latch nonzero write data,
  // other addresses read back a fixed function of the address
  logic [DW-1:0] smem [4];
  initial for (int i = 0; i < 4; i++) smem[i] = '0;
  always @(posedge clk) begin
    if (bus_addr < 20'd4) begin
      bus_rdata <= smem[bus_addr[1:0]];
      if (bus_wdata != '0) smem[bus_addr[1:0]] <= bus_wdata;
    end else begin
      bus_rdata <= bus_addr ^ 20'h5A5A5;
    end
  end

  logic [DW-1:0] mm [4];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] ad);
    if (ad < 20'd4) return mm[ad[1:0]];
    return ad ^ 20'h5A5A5;
  endfunction

  logic [AW-1:0] obs_a[$];
  logic [DW-1:0] obs_d[$];
  int            obs_end;
  int            rsp_first;
  int            rsp_cyc;
  logic [DW-1:0] rsp_val;
  bit            rsp_stable;
  bit            ready_ok;
  bit            tmo;
  logic [AW-1:0] end_addr;

  task automatic issue(input logic [1:0] k, input logic [2:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] ad, input int dly);
    int cyc;
    obs_a.delete();
    obs_d.delete();
    rsp_first  = 0;
    rsp_cyc    = 0;
    rsp_val    = '0;
    rsp_stable = 1'b1;
    ready_ok   = 1'b1;
    tmo        = 1'b0;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!cmd_ready) tmo = 1'b1;
    rsp_ready = (dly == 0);
    cmd_kind  = k;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_addr  = ad;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    while (busy && cyc < 60) begin
      if (cmd_ready) ready_ok = 1'b0;
      if (rsp_valid) begin
        if (rsp_cyc == 0) begin
          rsp_first = cyc;
          rsp_val   = rsp_data;
        end else if (rsp_data !== rsp_val) begin
          rsp_stable = 1'b0;
        end
        rsp_cyc++;
        rsp_ready = (rsp_cyc > dly);
      end else begin
        obs_a.push_back(bus_addr);
        obs_d.push_back(bus_wdata);
      end
      @(negedge clk);
      cyc++;
    end
    if (busy) tmo = 1'b1;
    obs_end   = cyc;
    end_addr  = bus_addr;
    rsp_ready = 1'b0;
  endtask

  task automatic model_check(input string tag, input logic [1:0] k,
                             input logic [2:0] op,
                             input logic [DW-1:0] a,
                             input logic [DW-1:0] b,
                             input logic [AW-1:0] ad, input int dly);
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    int nmis;
    int n;
    int rcyc;
    case (k)
      2'b00: begin
        ea.push_back(20'd0); ed.push_back(DW'(op));
        ea.push_back(20'd1); ed.push_back(a);
        ea.push_back(20'd2); ed.push_back(b);
      end
      2'b01: begin
        ea.push_back(20'd3); ed.push_back(a);
      end
      2'b10: begin
        ea.push_back(ad);   ed.push_back('0);
        ea.push_back(IDLE); ed.push_back('0);
      end
      default: ;
    endcase
    rcyc = (k == 2'b10) ? dly + 1 : 0;
    chk({tag, " trace_len"}, obs_a.size(), ea.size());
    n = (obs_a.size() < ea.size()) ? obs_a.size() : ea.size();
    nmis = 0;
    for (int i = 0; i < n; i++)
      if (obs_a[i] !== ea[i] || obs_d[i] !== ed[i]) nmis++;
    chk({tag, " trace_mismatches"}, nmis, 0);
    chk({tag, " end_cycle"}, obs_end, ea.size() + rcyc + 1);
    chk({tag, " rsp_cycles"}, rsp_cyc, rcyc);
    if (k == 2'b10) begin
      chk({tag, " rsp_first"}, rsp_first, 3);
      chk({tag, " rsp_data"}, rsp_val, rd_model(ad));
      chk({tag, " rsp_stable"}, rsp_stable, 1);
    end
    chk({tag, " ready_low_busy"}, ready_ok, 1);
    chk({tag, " idle_addr_after"}, end_addr, IDLE);
    chk({tag, " timeout"}, tmo, 0);
    if (k == 2'b00) begin
      if (op != '0) mm[0] = DW'(op);
      if (a != '0)  mm[1] = a;
      if (b != '0)  mm[2] = b;
    end
    if (k == 2'b01 && a != '0) mm[3] = a;
  endtask

  typedef struct {
    logic [1:0]    k;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] ad;
    int            dly;
    int            n_wr;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    int            endc;
    int            rfirst;
    logic [DW-1:0] rsp;
  } vec_t;

  vec_t vt[8];

  logic [AW-1:0] g_obs_a[$];
  logic [DW-1:0] g_obs_d[$];
  logic [AW-1:0] g_ea[$];
  logic [DW-1:0] g_ed[$];

  task automatic g_push_wr(input logic [AW-1:0] ad,
                           input logic [DW-1:0] d);
    g_ea.push_back(ad);
    g_ed.push_back(d);
    for (int i = 0; i < GAP2; i++) begin
      g_ea.push_back(IDLE);
      g_ed.push_back('0);
    end
  endtask

  task automatic g_run(input string tag, input logic [1:0] k,
                       input logic [DW-1:0] a);
    int endc;
    int nmis;
    g_obs_a.delete();
    g_obs_d.delete();
    g_ea.delete();
    g_ed.delete();
    case (k)
      2'b00: begin
        g_push_wr(20'd0, 20'd1);
        g_push_wr(20'd1, a);
        g_push_wr(20'd2, 20'd3);
      end
      2'b01: g_push_wr(20'd3, a);
      default: begin
        g_ea.push_back(20'h00042); g_ed.push_back('0);
        g_ea.push_back(IDLE);      g_ed.push_back('0);
        g_ea.push_back(IDLE);      g_ed.push_back('0);
      end
    endcase
    @(negedge clk);
    g_cmd_kind  = k;
    g_cmd_op    = ALU_SUB;
    g_cmd_a     = a;
    g_cmd_b     = 20'h00003;
    g_cmd_addr  = 20'h00042;
    g_cmd_valid = 1'b1;
    @(negedge clk);
    g_cmd_valid = 1'b0;
    endc = 1;
    while (g_busy && endc < 40) begin
      g_obs_a.push_back(g_bus_addr);
      g_obs_d.push_back(g_bus_wdata);
      @(negedge clk);
      endc++;
    end
    chk({tag, " len"}, g_obs_a.size(), g_ea.size());
    nmis = 0;
    for (int i = 0; i < g_obs_a.size() && i < g_ea.size(); i++)
      if (g_obs_a[i] !== g_ea[i] || g_obs_d[i] !== g_ed[i]) nmis++;
    chk({tag, " mismatches"}, nmis, 0);
    chk({tag, " ready_cycle"}, endc, g_ea.size() + 1);
    chk({tag, " ready_after"}, g_cmd_ready, 1);
    chk({tag, " idle_after"}, g_bus_addr, IDLE);
  endtask

  initial begin
    logic [DW-1:0] keep1;
    for (int i = 0; i < 4; i++) mm[i] = '0;

    vt[0] = '{2'b00, ALU_SUB, 20'h00005, 20'h00003, 20'h0, 0,
              3, 20'h0, 20'h00001, 4, 0, 20'h0};
    vt[1] = '{2'b01, ALU_ADD, 20'hABCDE, 20'h0, 20'h0, 0,
              1, 20'h3, 20'hABCDE, 2, 0, 20'h0};
    vt[2] = '{2'b10, ALU_ADD, 20'h0, 20'h0, 20'h3, 0,
              2, 20'h3, 20'h0, 4, 3, 20'hABCDE};
    vt[3] = '{2'b10, ALU_ADD, 20'h0, 20'h0, 20'h3, 5,
              2, 20'h3, 20'h0, 9, 3, 20'hABCDE};
    vt[4] = '{2'b11, ALU_OR, 20'h11111, 20'h22222, 20'h3, 0,
              0, 20'h0, 20'h0, 1, 0, 20'h0};
    vt[5] = '{2'b10, ALU_ADD, 20'h0, 20'h0, 20'h12345, 0,
              2, 20'h12345, 20'h0, 4, 3, 20'h486E0};
    vt[6] = '{2'b00, 3'd7, 20'hFFFFF, 20'h0, 20'h0, 0,
              3, 20'h0, 20'h00007, 4, 0, 20'h0};
    vt[7] = '{2'b10, ALU_ADD, 20'h0, 20'h0, 20'h1, 2,
              2, 20'h1, 20'h0, 6, 3, 20'hFFFFF};

    // reset held with a command offered
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst busy c%0d", i), busy, 0);
      chk($sformatf("rst addr c%0d", i), bus_addr, IDLE);
    end
    chk("rst wdata", bus_wdata, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst busy", busy, 0);
    chk("post_rst addr", bus_addr, IDLE);

    g_run("gap exec", 2'b00, 20'h00005);
    g_run("gap store", 2'b01, 20'h0BEEF);
    g_run("gap read", 2'b10, 20'h0);

    for (int i = 0; i < 8; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      issue(vt[i].k, vt[i].op, vt[i].a, vt[i].b, vt[i].ad, vt[i].dly);
      chk({t, " n_wr"}, obs_a.size(), vt[i].n_wr);
      if (vt[i].n_wr > 0 && obs_a.size() > 0) begin
        chk({t, " addr0"}, obs_a[0], vt[i].a0);
        chk({t, " data0"}, obs_d[0], vt[i].d0);
      end
      chk({t, " end"}, obs_end, vt[i].endc);
      chk({t, " rsp_first"}, rsp_first, vt[i].rfirst);
      if (vt[i].rfirst > 0) chk({t, " rsp"}, rsp_val, vt[i].rsp);
      model_check(t, vt[i].k, vt[i].op, vt[i].a, vt[i].b,
                  vt[i].ad, vt[i].dly);
    end

    // reset in the middle of an EXEC
    issue(2'b01, ALU_ADD, 20'h13579, 20'h0, 20'h0, 0);
    model_check("pre_rst store", 2'b01, ALU_ADD, 20'h13579,
                20'h0, 20'h0, 0);
    keep1 = mm[1];
    cmd_kind  = 2'b00;
    cmd_op    = ALU_AND;
    cmd_a     = 20'h00006;
    cmd_b     = 20'h00009;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid W_OP addr", bus_addr, 20'h0);
    @(negedge clk);
    chk("mid W_A addr", bus_addr, 20'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst addr", bus_addr, IDLE);
    chk("mid rst wdata", bus_wdata, 0);
    chk("mid rst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mm[0] = DW'(ALU_AND);
    @(negedge clk);
    chk("mid post busy", busy, 0);
    chk("mid post rsp_valid", rsp_valid, 0);
    issue(2'b10, ALU_ADD, 20'h0, 20'h0, 20'h3, 1);
    chk("mid read slot3", rsp_val, 20'h13579);
    model_check("mid read3", 2'b10, ALU_ADD, 20'h0, 20'h0, 20'h3, 1);
    issue(2'b10, ALU_ADD, 20'h0, 20'h0, 20'h1, 0);
    chk("mid read slot1", rsp_val, keep1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]    k;
      logic [2:0]    op;
      logic [DW-1:0] a, b;
      logic [AW-1:0] ad;
      int            dly;
      k   = 2'($urandom_range(0, 3));
      op  = 3'($urandom_range(0, 7));
      a   = 20'($urandom);
      b   = 20'($urandom);
      ad  = ($urandom_range(0, 1) == 0) ? 20'($urandom_range(0, 3))
                                        : 20'($urandom);
      dly = $urandom_range(0, 3);
      issue(k, op, a, b, ad, dly);
      model_check($sformatf("rnd%0d", i), k, op, a, b, ad, dly);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
